// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types, defaults and byte-lane mask helper for the data RAM
package ram_pkg;

  typedef enum logic {ST_CLEAR, ST_IDLE} ram_state_t;

  localparam int DATA_W_DFLT = 32;
  localparam int BYTE_W_DFLT = 8;
  localparam int ADDR_W_DFLT = 10;
  localparam int NB          = DATA_W_DFLT / BYTE_W_DFLT;
  localparam int DEPTH       = 2 ** ADDR_W_DFLT;

  // Mask is built at a fixed maximum width; callers cast it down to their DATA_W.
  localparam int MAX_NB = 32;
  localparam int MAX_W  = 256;

  function automatic logic [MAX_W-1:0] be_to_mask(input logic [MAX_NB-1:0] be,
                                                  input int byte_w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_W; k++) begin
      if ((k / byte_w) < MAX_NB) m[k] = be[5'(k / byte_w)];
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_be_sync_if.sv
// rtl/ram_be_sync_if.sv - load/store-unit port bundle of the byte-enable data RAM
interface ram_be_sync_if
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int BYTE_W = BYTE_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT
);
  logic [ADDR_W-1:0]        addr;
  logic [DATA_W-1:0]        d;
  logic [DATA_W/BYTE_W-1:0] be;
  logic                     we;
  logic                     re;
  logic [DATA_W-1:0]        q;
  logic                     q_valid;
  logic                     busy;

  modport master (output addr, d, be, we, re, input q, q_valid, busy);
  modport slave  (input addr, d, be, we, re, output q, q_valid, busy);
endinterface

// File: rtl/ram_clear_seq.sv
// rtl/ram_clear_seq.sv - post-reset zeroing sequencer: walks every word address once
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DFLT,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam int              WORDS = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(WORDS - 1);

  ram_state_t      state, state_nx;
  logic [ADDR_W:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    busy     = 1'b0;
    clr_we   = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        cnt_nx = cnt + (ADDR_W+1)'(1);
        if (cnt == LAST) state_nx = ST_IDLE;
      end
      default: ;
    endcase
  end

  assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/ram_be_sync.sv
// rtl/ram_be_sync.sv - single-port byte-enable data RAM, 1-cycle registered read
// RAM_FWD_EN: same-edge write+read returns the merged (write-first) word instead of the old one.
module ram_be_sync
  import ram_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int BYTE_W     = BYTE_W_DFLT,
  parameter int ADDR_W     = ADDR_W_DFLT,
  parameter int INIT_CLEAR = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_be_sync_if.slave  bus
);
  localparam int WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [WORDS];

  logic              busy, clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] lane_mask, old_word, wr_word, rd_word;
  logic              user_we, user_re;
  logic [DATA_W-1:0] q_r;
  logic              q_valid_r;

  ram_clear_seq #(
    .ADDR_W     (ADDR_W),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign lane_mask = DATA_W'(be_to_mask(MAX_NB'(bus.be), BYTE_W));
  assign old_word  = mem[bus.addr];
  assign wr_word   = (old_word & ~lane_mask) | (bus.d & lane_mask);
  assign user_we   = bus.we & ~busy;
  assign user_re   = bus.re & ~busy;

`ifdef RAM_FWD_EN
  assign rd_word = bus.we ? wr_word : old_word;
`else
  assign rd_word = old_word;
`endif

  // The array itself has no reset; the clear sequencer owns the write port while busy.
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    else if (user_we) mem[bus.addr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      q_valid_r <= user_re;
      if (user_re) q_r <= rd_word;
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_ram_be_sync.sv
// tb/tb_ram_be_sync.sv - directed and random scoreboard bench for ram_be_sync (ADDR_W=4)
module tb_ram_be_sync;
  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int AW    = 4;
  localparam int NBL   = DW / BW;
  localparam int WORDS = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_be_sync_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) bif ();

  ram_be_sync #(
    .DATA_W     (DW),
    .BYTE_W     (BW),
    .ADDR_W     (AW),
    .INIT_CLEAR (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [WORDS];
  logic [DW-1:0] exp_q [$];
  logic          pend = 1'b0;
  int            busy_left = 0;

  // Output monitor: pend was set by the driver at the previous falling edge.
  always @(posedge clk) begin
    logic          ev;
    logic [DW-1:0] e;
    ev = pend;
    #1;
    checks++;
    assert (bif.q_valid === ev) else begin
      errors++;
      $error("FAIL q_valid: observed %0b expected %0b", bif.q_valid, ev);
    end
    if (ev) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL scoreboard_empty: observed %0d entries expected >0", exp_q.size());
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (bif.q === e) else begin
          errors++;
          $error("FAIL q: observed %08h expected %08h", bif.q, e);
        end
      end
    end
  end

  task automatic step(input logic we, input logic re, input logic [AW-1:0] a,
                      input logic [DW-1:0] dd, input logic [NBL-1:0] b,
                      input logic kexp, input logic [DW-1:0] k);
    logic          acc;
    logic [DW-1:0] old, mrg;
    @(negedge clk);
    checks++;
    assert (bif.busy === (busy_left > 0)) else begin
      errors++;
      $error("FAIL busy: observed %0b expected %0b", bif.busy, busy_left > 0);
    end
    acc = (busy_left == 0);
    if (busy_left > 0) busy_left--;
    bif.we = we; bif.re = re; bif.addr = a; bif.d = dd; bif.be = b;
    old = mdl[a];
    for (int i = 0; i < NBL; i++) mrg[i*BW +: BW] = b[i] ? dd[i*BW +: BW] : old[i*BW +: BW];
    pend = acc && re;
    if (acc && re) begin
      if (kexp) exp_q.push_back(k);
`ifdef RAM_FWD_EN
      else exp_q.push_back(we ? mrg : old);
`else
      else exp_q.push_back(old);
`endif
    end
    if (acc && we) mdl[a] = mrg;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] dd, input logic [NBL-1:0] b);
    step(1'b1, 1'b0, a, dd, b, 1'b0, '0);
  endtask

  task automatic rdk(input logic [AW-1:0] a, input logic [DW-1:0] k);
    step(1'b0, 1'b1, a, '0, '0, 1'b1, k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bif.we = 1'b0; bif.re = 1'b0; bif.addr = '0; bif.d = '0; bif.be = '0;
    pend  = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (bif.q === '0) else begin
      errors++; $error("FAIL rst_q: observed %08h expected %08h", bif.q, 32'h0);
    end
    checks++;
    assert (bif.q_valid === 1'b0) else begin
      errors++; $error("FAIL rst_q_valid: observed %0b expected 0", bif.q_valid);
    end
    checks++;
    assert (bif.busy === 1'b1) else begin
      errors++; $error("FAIL rst_busy: observed %0b expected 1", bif.busy);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    busy_left = WORDS;
    for (int i = 0; i < WORDS; i++) mdl[i] = '0;
    exp_q.delete();
  endtask

  initial begin
    logic [DW-1:0] same_exp;
    bif.we = 1'b0; bif.re = 1'b0; bif.addr = '0; bif.d = '0; bif.be = '0;
    do_reset();

    // Requests during the clear must be ignored and never raise q_valid.
    for (int i = 0; i < WORDS; i++) step(1'b1, 1'b1, AW'(i), 32'hFFFF_FFFF, 4'hF, 1'b0, '0);
    for (int i = 0; i < WORDS; i++) rdk(AW'(i), 32'h0000_0000);
    idle(1);

    wr(4'd3, 32'hDEAD_BEEF, 4'b1111);
    wr(4'd3, 32'h1122_3344, 4'b0101);
    rdk(4'd3, 32'hDE22_BE44);
    idle(1);

    wr(4'd5, 32'hAAAA_AAAA, 4'b1111);
`ifdef RAM_FWD_EN
    same_exp = 32'h5555_5555;
`else
    same_exp = 32'hAAAA_AAAA;
`endif
    step(1'b1, 1'b1, 4'd5, 32'h5555_5555, 4'b1111, 1'b1, same_exp);
    rdk(4'd5, 32'h5555_5555);

    wr(4'd7, 32'h1234_5678, 4'b0000);
    rdk(4'd7, 32'h0000_0000);

    wr(4'd0, 32'd1, 4'hF);
    wr(4'd1, 32'd2, 4'hF);
    wr(4'd2, 32'd3, 4'hF);
    rdk(4'd0, 32'd1);
    rdk(4'd1, 32'd2);
    rdk(4'd2, 32'd3);
    idle(1);

    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, WORDS-1)),
           DW'($urandom), NBL'($urandom_range(0, 15)), 1'b0, '0);

    wr(4'd9, 32'hCAFE_F00D, 4'hF);
    rdk(4'd9, 32'hCAFE_F00D);
    idle(1);
    do_reset();
    idle(7);
    do_reset();
    idle(WORDS);
    rdk(4'd3, 32'h0000_0000);
    rdk(4'd9, 32'h0000_0000);
    rdk(4'd15, 32'h0000_0000);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
